imem_uart_loader: RTL

- Instruction-memory source for the CPU top, replacing the static instruction registers.
- Receives a program image over a UART (8N1) and stores it as 32-bit words in an internal array.
- Serves the CPU's combinational instruction fetch port.
- Holds the CPU in reset until a complete image has loaded, then releases it.

---
 rtl/imem_uart_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: instruction memory that is filled over an 8N1 UART link.
// A program image (0xA5, word count N, 4*N little-endian bytes) is written
// into an internal word array; the CPU is held in reset until a complete
// image has landed. The fetch port is purely combinational.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match before the image is accepted.
module imem_uart_loader #(
  parameter int DEPTH        = 64,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        CK_REF,
  input  logic        RST,
  input  logic        UART_RX,
  input  logic [31:0] INST_MEM_ADDRESS_BUS,
  output logic [31:0] INST_MEM_DATA_BUS,
  output logic        CPU_RST_N,
  output logic        LOAD_BUSY,
  output logic        LOAD_ERR,
  output logic [7:0]  WORDS_LOADED
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_L = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_L = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]  DEPTH_L = 9'(DEPTH);
  localparam logic [31:0] NOP_L   = 32'h0000_0013;
  localparam logic [7:0]  SYNC_L  = 8'hA5;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_COUNT = 3'd1,
    L_DATA  = 3'd2,
    L_CHECK = 3'd3,
    L_DONE  = 3'd4
  } ld_state_t;
`else
  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_COUNT = 3'd1,
    L_DATA  = 3'd2,
    L_DONE  = 3'd4
  } ld_state_t;
`endif

  // ---------------------------------------------------------------- RX side
  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  rx_state_t     rx_state_r;
  rx_state_t     rx_state_nxt_s;
  logic [CW-1:0] rx_cnt_r;
  logic [CW-1:0] rx_cnt_nxt_s;
  logic [2:0]    rx_bit_r;
  logic [7:0]    rx_shift_r;
  logic          rx_shift_en_s;
  logic          rx_bit_clr_s;
  logic          rx_valid_s;
  logic          rx_valid_r;
  logic          rx_ferr_s;
  logic          rx_ferr_r;
  logic          rx_fall_s;
  logic          half_done_s;
  logic          bit_done_s;

  assign rx_fall_s   = rx_prev_r & ~rx_sync_r;
  assign half_done_s = (rx_cnt_r == HALF_L);
  assign bit_done_s  = (rx_cnt_r == FULL_L);

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(posedge CK_REF) begin
    if (RST) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= UART_RX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX state register.
  always_ff @(posedge CK_REF) begin
    if (RST) begin
      rx_state_r <= R_IDLE;
    end else begin
      rx_state_r <= rx_state_nxt_s;
    end
  end

  // RX next-state: start edge, mid-start glitch filter, 8 data bits, stop bit.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    case (rx_state_r)
      R_IDLE: begin
        if (rx_fall_s) rx_state_nxt_s = R_START;
        else           rx_state_nxt_s = R_IDLE;
      end
      R_START: begin
        if (half_done_s) rx_state_nxt_s = rx_sync_r ? R_IDLE : R_DATA;
        else             rx_state_nxt_s = R_START;
      end
      R_DATA: begin
        if (bit_done_s && (rx_bit_r == 3'd7)) rx_state_nxt_s = R_STOP;
        else                                  rx_state_nxt_s = R_DATA;
      end
      R_STOP: begin
        if (bit_done_s) rx_state_nxt_s = R_IDLE;
        else            rx_state_nxt_s = R_STOP;
      end
      default: rx_state_nxt_s = R_IDLE;
    endcase
  end

  // RX outputs: bit-timer next value, data-bit strobe and end-of-frame pulses.
  always_comb begin
    rx_cnt_nxt_s  = {CW{1'b0}};
    rx_shift_en_s = 1'b0;
    rx_bit_clr_s  = 1'b0;
    rx_valid_s    = 1'b0;
    rx_ferr_s     = 1'b0;
    case (rx_state_r)
      R_IDLE: begin
        rx_bit_clr_s = 1'b1;
      end
      R_START: begin
        if (half_done_s) rx_cnt_nxt_s = {CW{1'b0}};
        else             rx_cnt_nxt_s = rx_cnt_r + CW'(1);
      end
      R_DATA: begin
        rx_shift_en_s = bit_done_s;
        if (bit_done_s) rx_cnt_nxt_s = {CW{1'b0}};
        else            rx_cnt_nxt_s = rx_cnt_r + CW'(1);
      end
      R_STOP: begin
        rx_valid_s = bit_done_s & rx_sync_r;
        rx_ferr_s  = bit_done_s & ~rx_sync_r;
        if (bit_done_s) rx_cnt_nxt_s = {CW{1'b0}};
        else            rx_cnt_nxt_s = rx_cnt_r + CW'(1);
      end
      default: rx_bit_clr_s = 1'b1;
    endcase
  end

  // RX datapath: bit timer, LSB-first shift register and one-cycle pulses.
  always_ff @(posedge CK_REF) begin
    if (RST) begin
      rx_cnt_r   <= {CW{1'b0}};
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_cnt_r   <= rx_cnt_nxt_s;
      rx_valid_r <= rx_valid_s;
      rx_ferr_r  <= rx_ferr_s;
      if (rx_bit_clr_s) begin
        rx_bit_r <= 3'd0;
      end else if (rx_shift_en_s) begin
        rx_bit_r   <= rx_bit_r + 3'd1;
        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
      end
    end
  end

  // ------------------------------------------------------------ loader FSM
  ld_state_t   ld_state_r;
  ld_state_t   ld_state_nxt_s;
  logic        cpu_rst_n_r, cpu_rst_n_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        err_r, err_nxt_s;
  logic [7:0]  words_r, words_nxt_s;
  logic [7:0]  n_r, n_nxt_s;
  logic [7:0]  wptr_r, wptr_nxt_s;
  logic [1:0]  byte_idx_r, byte_idx_nxt_s;
  logic [23:0] word_r, word_nxt_s;
  logic        mem_we_s;
  logic [31:0] mem_wdata_s;
  logic        count_bad_s;
  logic        last_word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_r, csum_nxt_s;
`endif

  logic [31:0] mem_r [0:DEPTH-1];

  assign count_bad_s = (rx_shift_r == 8'd0) || ({1'b0, rx_shift_r} > DEPTH_L);
  assign last_word_s = (({1'b0, wptr_r} + 9'd1) == {1'b0, n_r});
  assign mem_wdata_s = {rx_shift_r, word_r};

  // Loader state register.
  always_ff @(posedge CK_REF) begin
    if (RST) begin
      ld_state_r <= L_IDLE;
    end else begin
      ld_state_r <= ld_state_nxt_s;
    end
  end

  // Loader next-state; a framing error anywhere abandons the image.
  always_comb begin
    ld_state_nxt_s = ld_state_r;
    if (rx_ferr_r) begin
      ld_state_nxt_s = L_IDLE;
    end else begin
      case (ld_state_r)
        L_IDLE: begin
          if (rx_valid_r && (rx_shift_r == SYNC_L)) ld_state_nxt_s = L_COUNT;
          else                                      ld_state_nxt_s = L_IDLE;
        end
        L_COUNT: begin
          if (rx_valid_r) ld_state_nxt_s = count_bad_s ? L_IDLE : L_DATA;
          else            ld_state_nxt_s = L_COUNT;
        end
        L_DATA: begin
          if (rx_valid_r && (byte_idx_r == 2'd3) && last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            ld_state_nxt_s = L_CHECK;
`else
            ld_state_nxt_s = L_DONE;
`endif
          end else begin
            ld_state_nxt_s = L_DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        L_CHECK: begin
          if (rx_valid_r) ld_state_nxt_s = (rx_shift_r == csum_r) ? L_DONE : L_IDLE;
          else            ld_state_nxt_s = L_CHECK;
        end
`endif
        L_DONE:  ld_state_nxt_s = L_IDLE;
        default: ld_state_nxt_s = L_IDLE;
      endcase
    end
  end

  // Loader outputs: next values of status registers, word assembly and memory write.
  always_comb begin
    cpu_rst_n_nxt_s = cpu_rst_n_r;
    busy_nxt_s      = busy_r;
    err_nxt_s       = err_r;
    words_nxt_s     = words_r;
    n_nxt_s         = n_r;
    wptr_nxt_s      = wptr_r;
    byte_idx_nxt_s  = byte_idx_r;
    word_nxt_s      = word_r;
    mem_we_s        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_nxt_s      = csum_r;
`endif
    if (rx_ferr_r) begin
      // CPU reset is left as is: mid-load it is already asserted.
      err_nxt_s  = 1'b1;
      busy_nxt_s = 1'b0;
    end else begin
      case (ld_state_r)
        L_IDLE: begin
          if (rx_valid_r && (rx_shift_r == SYNC_L)) begin
            cpu_rst_n_nxt_s = 1'b0;
            busy_nxt_s      = 1'b1;
            err_nxt_s       = 1'b0;
          end else begin
            cpu_rst_n_nxt_s = cpu_rst_n_r;
          end
        end
        L_COUNT: begin
          if (rx_valid_r) begin
            if (count_bad_s) begin
              err_nxt_s  = 1'b1;
              busy_nxt_s = 1'b0;
            end else begin
              n_nxt_s        = rx_shift_r;
              wptr_nxt_s     = 8'd0;
              byte_idx_nxt_s = 2'd0;
              word_nxt_s     = 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum_nxt_s     = 8'd0;
`endif
            end
          end else begin
            n_nxt_s = n_r;
          end
        end
        L_DATA: begin
          if (rx_valid_r) begin
            byte_idx_nxt_s = byte_idx_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_nxt_s     = csum_r ^ rx_shift_r;
`endif
            case (byte_idx_r)
              2'd0:    word_nxt_s[7:0]   = rx_shift_r;
              2'd1:    word_nxt_s[15:8]  = rx_shift_r;
              2'd2:    word_nxt_s[23:16] = rx_shift_r;
              default: begin
                mem_we_s   = 1'b1;
                wptr_nxt_s = wptr_r + 8'd1;
              end
            endcase
          end else begin
            byte_idx_nxt_s = byte_idx_r;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        L_CHECK: begin
          if (rx_valid_r && (rx_shift_r != csum_r)) begin
            err_nxt_s  = 1'b1;
            busy_nxt_s = 1'b0;
          end else begin
            err_nxt_s = err_r;
          end
        end
`endif
        L_DONE: begin
          words_nxt_s     = n_r;
          busy_nxt_s      = 1'b0;
          cpu_rst_n_nxt_s = 1'b1;
        end
        default: begin
          busy_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Loader register bank; all outputs come straight from these flops.
  always_ff @(posedge CK_REF) begin
    if (RST) begin
      cpu_rst_n_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      words_r     <= 8'd0;
      n_r         <= 8'd0;
      wptr_r      <= 8'd0;
      byte_idx_r  <= 2'd0;
      word_r      <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      cpu_rst_n_r <= cpu_rst_n_nxt_s;
      busy_r      <= busy_nxt_s;
      err_r       <= err_nxt_s;
      words_r     <= words_nxt_s;
      n_r         <= n_nxt_s;
      wptr_r      <= wptr_nxt_s;
      byte_idx_r  <= byte_idx_nxt_s;
      word_r      <= word_nxt_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r      <= csum_nxt_s;
`endif
    end
  end

  // Instruction array write port; contents survive reset by design.
  always_ff @(posedge CK_REF) begin
    if (mem_we_s) begin
      mem_r[wptr_r[AW-1:0]] <= mem_wdata_s;
    end
  end

  // Combinational fetch: only words of the last good image are visible, else NOP.
  always_comb begin
    if ((INST_MEM_ADDRESS_BUS[31:8] == 24'd0) && (INST_MEM_ADDRESS_BUS[7:0] < words_r)) begin
      INST_MEM_DATA_BUS = mem_r[INST_MEM_ADDRESS_BUS[AW-1:0]];
    end else begin
      INST_MEM_DATA_BUS = NOP_L;
    end
  end

  assign CPU_RST_N    = cpu_rst_n_r;
  assign LOAD_BUSY    = busy_r;
  assign LOAD_ERR     = err_r;
  assign WORDS_LOADED = words_r;

endmodule
